// File: rtl/argmax_seq.sv
// argmax_seq
//   Sequential argmax over the packed signed outputs of the output-layer
//   neuron array. A start/ack handshake captures all NCLS scores at once.
//   The captured scores are then scanned one comparison per cycle. The
//   winning index and its score are reported alongside a one-cycle done pulse.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset (overrides start)
//   start     : request to capture scores and begin a classification
//   scores    : packed signed scores, class i at scores[i*WIDTH +: WIDTH]
//   ack       : one-cycle pulse, start accepted and scores captured
//   busy      : high while scanning
//   done      : one-cycle pulse, class_idx/max_val valid from this cycle
//   class_idx : index of the maximum score (lowest index wins ties)
//   max_val   : signed maximum score, bit-identical to the captured score
module argmax_seq #(
  parameter int WIDTH = 8,
  parameter int NCLS  = 10,
  parameter int IDXW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NCLS*WIDTH-1:0]   scores,
  output logic                    ack,
  output logic                    busy,
  output logic                    done,
  output logic [IDXW-1:0]         class_idx,
  output logic [WIDTH-1:0]        max_val
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NCLS*WIDTH-1:0]    r_cap;
  logic signed [WIDTH-1:0]  r_best_val;
  logic [IDXW-1:0]          r_best_idx;
  logic [IDXW-1:0]          r_cnt;
  logic                     r_ack;
  logic [IDXW-1:0]          r_class_idx;
  logic [WIDTH-1:0]         r_max_val;

  logic                     w_accept;
  logic                     w_last;
  logic signed [WIDTH-1:0]  w_cur_score;
  logic signed [WIDTH-1:0]  w_new_val;
  logic [IDXW-1:0]          w_new_idx;
  logic signed [WIDTH-1:0]  w_first_score;

  // Strict signed comparison: an equal later score never displaces the
  // current best, which is what makes the lowest index win ties.
  function automatic logic f_beats(input logic signed [WIDTH-1:0] cand,
                                   input logic signed [WIDTH-1:0] best);
    return cand > best;
  endfunction

  // Start is only honoured outside SCAN; a start during a scan is dropped.
  assign w_accept      = start && (r_state != S_SCAN);
  assign w_last        = (r_cnt == IDXW'(NCLS - 1));
  assign w_cur_score   = r_cap[int'(r_cnt)*WIDTH +: WIDTH];
  assign w_first_score = scores[WIDTH-1:0];

  always_comb begin
    w_new_val = r_best_val;
    w_new_idx = r_best_idx;
    if (f_beats(w_cur_score, r_best_val)) begin
      w_new_val = w_cur_score;
      w_new_idx = r_cnt;
    end
  end

  // A single-class job has nothing to scan and completes straight away.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (NCLS > 1) ? S_SCAN : S_DONE;
      end
      S_SCAN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) w_state_nxt = (NCLS > 1) ? S_SCAN : S_DONE;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cap       <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_cnt       <= '0;
      r_ack       <= 1'b0;
      r_class_idx <= '0;
      r_max_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_accept;
      if (w_accept) begin
        r_cap      <= scores;
        r_best_val <= w_first_score;
        r_best_idx <= '0;
        r_cnt      <= IDXW'(1);
        if (NCLS == 1) begin
          r_class_idx <= '0;
          r_max_val   <= w_first_score;
        end
      end else if (r_state == S_SCAN) begin
        r_best_val <= w_new_val;
        r_best_idx <= w_new_idx;
        // Outputs take the result of the final comparison, not the stale best.
        if (w_last) begin
          r_class_idx <= w_new_idx;
          r_max_val   <= w_new_val;
        end else begin
          r_cnt <= r_cnt + IDXW'(1);
        end
      end
    end
  end

  assign ack       = r_ack;
  assign busy      = (r_state == S_SCAN);
  assign done      = (r_state == S_DONE);
  assign class_idx = r_class_idx;
  assign max_val   = r_max_val;

endmodule

// File: tb/tb_argmax_seq.sv
// Testbench for argmax_seq: table-driven vectors, hand-written multi-cycle
// sequences (ignored start, back-to-back, mid-scan reset) and random jobs
// checked against a behavioural argmax model.
module tb_argmax_seq;
  localparam int WIDTH = 8;
  localparam int NCLS  = 10;
  localparam int IDXW  = 4;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [NCLS*WIDTH-1:0] scores;
  logic                  ack;
  logic                  busy;
  logic                  done;
  logic [IDXW-1:0]       class_idx;
  logic [WIDTH-1:0]      max_val;

  int n_tests = 0;
  int n_fail  = 0;

  argmax_seq #(.WIDTH(WIDTH), .NCLS(NCLS), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .start(start), .scores(scores),
    .ack(ack), .busy(busy), .done(done),
    .class_idx(class_idx), .max_val(max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sc[NCLS];
    int exp_idx;
    int exp_val;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [NCLS*WIDTH-1:0] pack(input int a[NCLS]);
    logic [NCLS*WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < NCLS; i++) p[i*WIDTH +: WIDTH] = WIDTH'(a[i]);
    return p;
  endfunction

  // Reference: the maximum value, then the first index that holds it.
  task automatic ref_argmax(input int a[NCLS], output int idx, output int val);
    val = a[0];
    foreach (a[i]) if (a[i] > val) val = a[i];
    idx = -1;
    for (int i = 0; i < NCLS; i++) if (idx < 0 && a[i] == val) idx = i;
  endtask

  function automatic int sval();
    return int'($signed(max_val));
  endfunction

  // Waits for done, returning the number of edges after the start edge.
  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 40) begin
      step();
      c++;
    end
  endtask

  task automatic run_job(input string tag, input int a[NCLS]);
    int ei, ev, c, hi, hv;
    ref_argmax(a, ei, ev);
    scores = pack(a);
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk({tag, "_ack"}, int'(ack), 1);
    chk({tag, "_busy"}, int'(busy), 1);
    wait_done(c);
    chk({tag, "_latency"}, c, NCLS - 1);
    chk({tag, "_idx"}, int'(class_idx), ei);
    chk({tag, "_val"}, sval(), ev);
    hi = int'(class_idx);
    hv = sval();
    step();
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_hold_idx"}, int'(class_idx), hi);
    chk({tag, "_hold_val"}, sval(), hv);
  endtask

  initial begin
    vec_t tbl[4];
    int   a[NCLS];
    int   b[NCLS];
    int   vq[3][NCLS];
    int   ei, ev, c;
    int   saw_done;

    tbl[0] = '{'{3, -5, 12, 7, 40, -128, 0, 39, 1, 2}, 4, 40};
    tbl[1] = '{'{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7}, 0, -7};
    tbl[2] = '{'{-1, -1, -1, 5, -1, -1, -1, -1, 5, -1}, 3, 5};
    tbl[3] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 127}, 9, 127};

    // Reset with start held high: nothing may respond.
    rst    = 1'b1;
    start  = 1'b1;
    scores = pack(tbl[0].sc);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ack", int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_idx", int'(class_idx), 0);
      chk("rst_val", sval(), 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("idle_ack", int'(ack), 0);

    // Table vectors with hand-derived expectations.
    for (int t = 0; t < 4; t++) begin
      run_job($sformatf("tbl%0d", t), tbl[t].sc);
      chk($sformatf("tbl%0d_const_idx", t), int'(class_idx), tbl[t].exp_idx);
      chk($sformatf("tbl%0d_const_val", t), sval(), tbl[t].exp_val);
    end

    // Scores change and start pulses mid-scan: both must be ignored.
    a = tbl[0].sc;
    b = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    scores = pack(a);
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("ign_ack0", int'(ack), 1);
    step();
    step();
    scores = pack(b);
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("ign_no_ack", int'(ack), 0);
    chk("ign_busy", int'(busy), 1);
    wait_done(c);
    chk("ign_latency", c + 3, NCLS - 1);
    chk("ign_idx", int'(class_idx), 4);
    chk("ign_val", sval(), 40);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ign_hold_idx", int'(class_idx), 4);
      chk("ign_hold_val", sval(), 40);
      chk("ign_hold_done", int'(done), 0);
    end

    // Back-to-back jobs with start held high.
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NCLS; i++) vq[j][i] = int'($urandom_range(0, 255)) - 128;
    scores = pack(vq[0]);
    start  = 1'b1;
    step();
    chk("b2b_ack0", int'(ack), 1);
    for (int j = 0; j < 3; j++) begin
      if (j < 2) scores = pack(vq[j+1]);
      else       start  = 1'b0;
      wait_done(c);
      chk("b2b_latency", c, NCLS - 1);
      ref_argmax(vq[j], ei, ev);
      chk("b2b_idx", int'(class_idx), ei);
      chk("b2b_val", sval(), ev);
      step();
      chk("b2b_ack", int'(ack), (j < 2) ? 1 : 0);
      chk("b2b_busy", int'(busy), (j < 2) ? 1 : 0);
      chk("b2b_done_pulse", int'(done), 0);
    end

    // Reset in the middle of a scan abandons the job.
    scores = pack(tbl[3].sc);
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_idx", int'(class_idx), 0);
    chk("mid_rst_val", sval(), 0);
    saw_done = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) saw_done = 1;
    end
    chk("mid_rst_no_done", saw_done, 0);
    run_job("after_rst", tbl[2].sc);

    // Random jobs, some drawn from a narrow range to force ties.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NCLS; i++)
        a[i] = (r % 3 == 0) ? int'($urandom_range(0, 3)) - 2
                            : int'($urandom_range(0, 255)) - 128;
      run_job($sformatf("rnd%0d", r), a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
